// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// 4 lines x 16 bytes. offset = addr[3:2], index = addr[5:4], tag = addr[31:6].
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   addr_in           - byte address of the access (addr[1:0] ignored)
//   wdata_in          - store data
//   is_load_in        - load word request
//   is_store_in       - store word request (wins when both are high)
//   rdata_out         - load data, non-zero only during a load hit
//   stall_req         - high while the access cannot complete this cycle
//   mem_req/mem_we    - main-memory line request, 1 = writeback, 0 = refill
//   mem_addr          - line-aligned memory address
//   mem_wdata         - victim line data for writeback
//   mem_rdata         - refill line data, valid with mem_ready
//   mem_ready         - one-cycle completion pulse from main memory
//
// state     | meaning
// IDLE      | serve hits; on a miss issue writeback or refill
// WRITEBACK | dirty victim line being written to memory
// REFILL    | requested line being fetched from memory

module data_cache (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  addr_in,
    input  logic [31:0]  wdata_in,
    input  logic         is_load_in,
    input  logic         is_store_in,
    output logic [31:0]  rdata_out,
    output logic         stall_req,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t       state;
    logic [3:0]   valid;
    logic [3:0]   dirty;
    logic [25:0]  tag_arr  [4];
    logic [127:0] data_arr [4];

    logic [1:0]   offset;
    logic [1:0]   index;
    logic [25:0]  tag;
    logic         req;
    logic         hit;
    logic         miss;
    logic [127:0] sel_line;
    logic [31:0]  sel_word;
    logic         unused_bits;

    assign offset      = addr_in[3:2];
    assign index       = addr_in[5:4];
    assign tag         = addr_in[31:6];
    assign unused_bits = ^addr_in[1:0];

    assign req      = is_load_in | is_store_in;
    assign hit      = (state == IDLE) && req && valid[index] && (tag_arr[index] == tag);
    assign miss     = (state == IDLE) && req && !hit;
    assign sel_line = data_arr[index];
    assign sel_word = sel_line[{offset, 5'b0} +: 32];

    // A store with both controls high is not a load, so no read data.
    assign rdata_out = (!reset && hit && !is_store_in) ? sel_word : 32'h0;
    assign stall_req = !reset && ((state != IDLE) || miss);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && is_store_in) begin
                        dirty[index] <= 1'b1;
                    end else if (miss) begin
                        mem_req <= 1'b1;
                        if (valid[index] && dirty[index]) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_arr[index], index, 4'b0};
                            mem_wdata <= data_arr[index];
                        end else begin
                            state    <= REFILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {addr_in[31:4], 4'b0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        dirty[index] <= 1'b0;
                        state        <= REFILL;
                        mem_we       <= 1'b0;
                        mem_addr     <= {addr_in[31:4], 4'b0};
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        valid[index] <= 1'b1;
                        dirty[index] <= 1'b0;
                        mem_req      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line data and tags carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (hit && is_store_in) begin
                data_arr[index][{offset, 5'b0} +: 32] <= wdata_in;
            end else if ((state == REFILL) && mem_ready) begin
                data_arr[index] <= mem_rdata;
                tag_arr[index]  <= tag;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  addr_in;
    logic [31:0]  wdata_in;
    logic         is_load_in;
    logic         is_store_in;
    logic [31:0]  rdata_out;
    logic         stall_req;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    data_cache dut (
        .clk         (clk),
        .reset       (reset),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .is_load_in  (is_load_in),
        .is_store_in (is_store_in),
        .rdata_out   (rdata_out),
        .stall_req   (stall_req),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ld;
        logic        st;
        logic        rdy;
        logic [31:0] exp_rdata;
        logic        exp_stall;
        string       name;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Services one miss: pulses mem_ready in the lat-th cycle of each memory
    // request and returns the stall length plus what was seen on the bus.
    task automatic run_miss(input int lat, input logic [127:0] line,
                            output int stalls, output bit saw_wb,
                            output logic [31:0] wb_addr, output logic [127:0] wb_data,
                            output logic [31:0] rf_addr);
        int cnt = 0;
        bit done = 0;
        stalls  = 0;
        saw_wb  = 0;
        wb_addr = '0;
        wb_data = '0;
        rf_addr = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!stall_req) begin
                done = 1;
                break;
            end
            stalls++;
            if (mem_req) begin
                cnt++;
                if (mem_we) begin
                    saw_wb  = 1;
                    wb_addr = mem_addr;
                    wb_data = mem_wdata;
                end else begin
                    rf_addr = mem_addr;
                end
                if (cnt == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = line;
                    cnt = 0;
                end
            end
            @(posedge clk);
            #1 mem_ready = 1'b0;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL miss_timeout: stall still high after 200 cycles");
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic ld, input logic st);
        addr_in     = a;
        wdata_in    = w;
        is_load_in  = ld;
        is_store_in = st;
    endtask

    int           stalls;
    bit           saw_wb;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic [31:0]  rf_addr;
    logic [127:0] line0;
    logic [127:0] line1;

    initial begin
        line0 = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        line1 = {32'h80C00003, 32'h80C00002, 32'h80C00001, 32'h80C00000};

        vecs[0] = '{32'h44, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, "store_hit_0x44"};
        vecs[1] = '{32'h44, 32'h0,        1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, "load_0x44"};
        vecs[2] = '{32'h40, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, "load_0x40"};
        vecs[3] = '{32'h48, 32'h0,        1'b1, 1'b0, 1'b0, 32'h22222222, 1'b0, "load_0x48"};
        vecs[4] = '{32'h4F, 32'h0,        1'b1, 1'b0, 1'b0, 32'h33333333, 1'b0, "load_0x4F_lowbits"};
        vecs[5] = '{32'h40, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, "idle_mem_ready"};
        vecs[6] = '{32'h4C, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, "load_store_both"};
        vecs[7] = '{32'h4C, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, "load_0x4C"};
        vecs[8] = '{32'h44, 32'h0,        1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, "load_0x44_again"};

        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_stall",     {127'b0, stall_req}, 128'd0);
        chk("rst_mem_req",   {127'b0, mem_req},   128'd0);
        chk("rst_mem_we",    {127'b0, mem_we},    128'd0);
        chk("rst_mem_addr",  {96'b0, mem_addr},   128'd0);
        chk("rst_mem_wdata", mem_wdata,           128'd0);
        chk("rst_rdata",     {96'b0, rdata_out},  128'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Cold miss on 0x40, refill answered in its 3rd cycle.
        drive(32'h40, 32'h0, 1'b1, 1'b0);
        run_miss(3, line0, stalls, saw_wb, wb_addr, wb_data, rf_addr);
        chk("cold_stall_cycles", 128'(stalls), 128'd4);
        chk("cold_no_wb",        {127'b0, saw_wb}, 128'd0);
        chk("cold_rf_addr",      {96'b0, rf_addr}, 128'h40);
        chk("cold_rdata",        {96'b0, rdata_out}, 128'hDEADBEEF);
        chk("cold_mem_req_drop", {127'b0, mem_req}, 128'd0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].ld, vecs[i].st);
            mem_ready = vecs[i].rdy;
            mem_rdata = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
            @(negedge clk);
            chk({vecs[i].name, "_rdata"},   {96'b0, rdata_out}, {96'b0, vecs[i].exp_rdata});
            chk({vecs[i].name, "_stall"},   {127'b0, stall_req}, {127'b0, vecs[i].exp_stall});
            chk({vecs[i].name, "_mem_req"}, {127'b0, mem_req},   128'd0);
        end
        @(posedge clk);
        #1 mem_ready = 1'b0;

        // Conflict miss on 0x84 evicts the dirty 0x40 line.
        drive(32'h84, 32'h0, 1'b1, 1'b0);
        run_miss(2, line1, stalls, saw_wb, wb_addr, wb_data, rf_addr);
        chk("evict_stall_cycles", 128'(stalls), 128'd5);
        chk("evict_saw_wb",       {127'b0, saw_wb}, 128'd1);
        chk("evict_wb_addr",      {96'b0, wb_addr}, 128'h40);
        chk("evict_wb_word0",     {96'b0, wb_data[31:0]},   128'hDEADBEEF);
        chk("evict_wb_word1",     {96'b0, wb_data[63:32]},  128'h12345678);
        chk("evict_wb_word3",     {96'b0, wb_data[127:96]}, 128'hA5A5A5A5);
        chk("evict_rf_addr",      {96'b0, rf_addr}, 128'h80);
        chk("evict_rdata",        {96'b0, rdata_out}, 128'h80C00001);

        // The refilled 0x80 line is clean, so going back to 0x40 needs no writeback.
        @(posedge clk);
        #1 drive(32'h40, 32'h0, 1'b1, 1'b0);
        run_miss(1, line0, stalls, saw_wb, wb_addr, wb_data, rf_addr);
        chk("clean_stall_cycles", 128'(stalls), 128'd2);
        chk("clean_no_wb",        {127'b0, saw_wb}, 128'd0);
        chk("clean_rf_addr",      {96'b0, rf_addr}, 128'h40);
        chk("clean_rdata",        {96'b0, rdata_out}, 128'hDEADBEEF);

        // Reset in the middle of a refill.
        @(posedge clk);
        #1 drive(32'hC0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("abort_miss_stall", {127'b0, stall_req}, 128'd1);
        @(negedge clk);
        chk("abort_refill_req",  {127'b0, mem_req}, 128'd1);
        chk("abort_refill_addr", {96'b0, mem_addr}, 128'hC0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(32'hC0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", {127'b0, mem_req},   128'd0);
        chk("abort_stall",   {127'b0, stall_req}, 128'd0);
        @(posedge clk);
        #1 drive(32'hC0, 32'h0, 1'b1, 1'b0);
        run_miss(1, line1, stalls, saw_wb, wb_addr, wb_data, rf_addr);
        chk("reload_stall_cycles", 128'(stalls), 128'd2);
        chk("reload_no_wb",        {127'b0, saw_wb}, 128'd0);
        chk("reload_rf_addr",      {96'b0, rf_addr}, 128'hC0);
        chk("reload_rdata",        {96'b0, rdata_out}, 128'h80C00000);

        @(posedge clk);
        #1 drive(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("final_idle_stall", {127'b0, stall_req}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL have ports: addr_in  input  32  byte address from the memory stage (ALU result).
REQ-004 SHALL have ports: wdata_in  input  32  store data (rs2).
REQ-005 SHALL have ports: is_load_in  input  1  load word request.
REQ-006 SHALL have ports: is_store_in  input  1  store word request.
REQ-007 SHALL have ports: rdata_out  output  32  load data, valid when a load hits.
REQ-008 SHALL have ports: stall_req  output  1  pipeline stall, high while the request cannot complete this cycle.
REQ-009 SHALL have ports: mem_req  output  1  main-memory line request.
REQ-010 SHALL have ports: mem_we  output  1  1 = line writeback, 0 = line refill.
REQ-011 SHALL have ports: mem_addr  output  32  line-aligned address, bits [3:0] = 0.
REQ-012 SHALL have ports: mem_wdata  output  128  dirty line data for writeback.
REQ-013 SHALL have ports: mem_rdata  input  128  refill line data, valid with mem_ready.
REQ-014 SHALL have ports: mem_ready  input  1  one-cycle completion pulse from main memory.

Function
REQ-015 SHALL be direct-mapped, write-back, write-allocate: 4 lines x 16 bytes; offset = addr[3:2] (word), index = addr[5:4], tag = addr[31:6] (26 bits); addr[1:0] ignored.
REQ-016 SHALL keep per line: valid, dirty, 26-bit tag, 128-bit data; word k occupies data bits [32k+31:32k].
REQ-017 SHALL treat is_load_in and is_store_in both high as a store.
REQ-018 SHALL define hit = request active AND line valid AND tag match, evaluated combinationally in state IDLE.
REQ-019 SHALL on load hit drive rdata_out with the selected word in the same cycle, stall_req = 0.
REQ-020 SHALL on store hit write wdata_in into the selected word and set dirty at the next rising edge, stall_req = 0.
REQ-021 SHALL drive rdata_out = 0 whenever no load hit is in progress.
REQ-022 SHALL on miss assert stall_req combinationally in that same cycle and hold it high until the cycle in which the access hits.
REQ-023 SHALL implement FSM states IDLE, WRITEBACK, REFILL.
REQ-024 SHALL transition IDLE -> WRITEBACK on miss with victim valid and dirty; IDLE -> REFILL on miss otherwise.
REQ-025 SHALL in WRITEBACK drive mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 4'b0}, mem_wdata = victim data; on mem_ready clear dirty and go to REFILL.
REQ-026 SHALL in REFILL drive mem_req = 1, mem_we = 0, mem_addr = {addr_in[31:4], 4'b0}; on mem_ready load mem_rdata, set valid, write tag, clear dirty, go to IDLE.
REQ-027 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable from request until the mem_ready cycle, and drop mem_req in the cycle after mem_ready.
REQ-028 SHALL, after refill, complete the pending access as a normal hit in IDLE; miss penalty = writeback latency + refill latency + 1 cycle.
REQ-029 SHALL ignore mem_ready in IDLE.
REQ-030 SHALL rely on the pipeline holding addr_in, wdata_in and the request controls stable while stall_req = 1.
REQ-031 SHALL, with no request active, keep stall_req = 0, mem_req = 0 and leave all state unchanged.

Reset
REQ-032 SHALL on reset clear all valid and dirty bits, enter IDLE, drive stall_req = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata_out = 0.
REQ-033 SHALL abort an in-flight WRITEBACK or REFILL when reset is asserted mid-operation, with no line updated and mem_req low in the following cycle.
REQ-034 SHALL keep line data and tag arrays unreset; only the valid and dirty bits are reset.

Verification
REQ-035 SHALL cover: load 0x40 after reset, mem_ready 3 cycles after mem_req with mem_rdata word0 = 0xDEADBEEF -> stall high 4 cycles, rdata_out = 0xDEADBEEF, mem_addr = 0x40, mem_we = 0.
REQ-036 SHALL cover: store 0x12345678 to 0x44 after line 0x40 is resident -> no stall; a following load of 0x44 returns 0x12345678.
REQ-037 SHALL cover: after REQ-036, load 0x84 (same index 0, different tag) -> WRITEBACK with mem_addr = 0x40, mem_we = 1, mem_wdata[63:32] = 0x12345678, then REFILL with mem_addr = 0x80.
REQ-038 SHALL cover: is_load_in and is_store_in both high on a hit -> treated as store, dirty set, rdata_out = 0.
REQ-039 SHALL cover: reset asserted during REFILL -> next cycle mem_req = 0, stall_req = 0; a reload of the same address misses again.
REQ-040 SHALL cover: mem_ready pulse while IDLE with no request -> no state change, mem_req stays 0.
